spi_slave_gen: RTL
==================

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame; frame width FW = DATA_W+2 (2 command bits + payload).
REQ-002 Parameter TX_WAIT_MAX, default 15: maximum cycles in READ_WAIT before timeout.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 SS_n  input  1  slave select, active low; frames are delimited by SS_n low.
REQ-006 MOSI  input  1  serial in, one bit sampled per clk while SS_n low.
REQ-007 tx_valid  input  1  tx_data valid; sampled only in READ_WAIT.
REQ-008 tx_data  input  DATA_W  read data to serialise.
REQ-009 rx_data  output  FW  received frame; rx_data[FW-1:FW-2] = command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
REQ-010 rx_valid  output  1  one-cycle pulse: rx_data holds a complete, valid frame.
REQ-011 MISO  output  1  serial out, MSB first.
REQ-012 frame_err  output  1  one-cycle pulse on abort, command mismatch or tx timeout.
REQ-013 busy  output  1  high whenever state != IDLE.

Function
REQ-014 States SHALL be IDLE, CHK_CMD, RX_SHIFT, READ_WAIT, TX_SHIFT, DONE; rd_addr_loaded is an internal flag.
REQ-015 IDLE: SS_n sampled low -> CHK_CMD next cycle; rx_valid, frame_err, MISO forced 0.
REQ-016 CHK_CMD: MOSI is the path-select bit and is not stored; expected command = 00/01 (MOSI=0), 10 (MOSI=1, rd_addr_loaded=0), 11 (MOSI=1, rd_addr_loaded=1); bit counter loads FW; -> RX_SHIFT.
REQ-017 RX_SHIFT: each cycle MOSI shifts into rx_data LSB (MSB-first frame); after FW bits, -> DONE (write, rd-addr) or READ_WAIT (rd-data).
REQ-018 rx_valid SHALL pulse for exactly one cycle, the cycle after the last frame bit is sampled, only if the received command matches the expected command; rx_data is stable while rx_valid is high.
REQ-019 Command mismatch: frame_err pulses in the rx_valid slot instead; rx_valid stays low; -> DONE; rd_addr_loaded unchanged.
REQ-020 Valid rd-addr frame SHALL set rd_addr_loaded.
REQ-021 READ_WAIT: first cycle with tx_valid=1 latches tx_data into the shift register -> TX_SHIFT; tx_valid is ignored in every other state.
REQ-022 READ_WAIT timeout: TX_WAIT_MAX cycles without tx_valid -> frame_err pulse, -> DONE, rd_addr_loaded unchanged.
REQ-023 TX_SHIFT: MISO presents tx_data[DATA_W-1] on the cycle after the latch, then one lower bit per cycle for DATA_W cycles; then MISO=0, rd_addr_loaded cleared, -> DONE.
REQ-024 DONE: MOSI ignored, MISO=0; SS_n high -> IDLE.
REQ-025 SS_n sampled high in CHK_CMD, RX_SHIFT, READ_WAIT or TX_SHIFT: -> IDLE next cycle, frame_err pulses one cycle, rx_valid not asserted, MISO=0, rd_addr_loaded unchanged.
REQ-026 SS_n high in the same cycle as the last RX bit: abort has priority; no rx_valid.
REQ-027 Bit counter width SHALL be $clog2(FW+1); no wrap-around beyond FW bits.

Reset
REQ-028 rst=1 at any cycle, including mid-frame, SHALL force next cycle: state IDLE, rx_data=0, rx_valid=0, MISO=0, frame_err=0, busy=0, rd_addr_loaded=0, counters 0.
REQ-029 After rst deasserts with SS_n already low, a frame SHALL start only after SS_n is seen low in IDLE (CHK_CMD next cycle).

Verification (DATA_W=8, TX_WAIT_MAX=15)
REQ-030 Write addr: SS_n low, select 0, frame 00_1010_0101 -> rx_data=0x0A5, rx_valid one cycle 12 clks after IDLE exit, frame_err=0.
REQ-031 Read: rd-addr frame 10_0000_0011 (rd_addr_loaded set), SS_n high; new frame select 1, 11_0000_0000, tx_valid=1 with tx_data=0x3C after 2 wait cycles -> MISO 0,0,1,1,1,1,0,0 on consecutive clks, then 0; rd_addr_loaded cleared.
REQ-032 Abort: SS_n high after 4 frame bits -> frame_err one cycle, rx_valid never high, rx_data retains partial bits, busy low next cycle.
REQ-033 Mismatch: rd_addr_loaded=0, select 1, frame 11_xxxx_xxxx -> frame_err pulse, no rx_valid, rd_addr_loaded stays 0.
REQ-034 Timeout: rd-data frame, tx_valid held 0 -> frame_err exactly 15 cycles after READ_WAIT entry, MISO stays 0.
REQ-035 Reset mid-TX: rst=1 at 3rd MISO bit -> all outputs 0 next cycle, rd_addr_loaded=0, next frame enters CHK_CMD normally.

Source files
------------

// File: rtl/spi_slave_gen_if.sv
// Bus bundle for the SPI slave: serial pins plus the parallel rx/tx side.
// The slave modport is the design's view; the master modport is the peer
// (the SPI master and the local data source/sink).
interface spi_slave_gen_if #(
    parameter int DATA_W = 8
);
    localparam int FW = DATA_W + 2;

    logic              SS_n;
    logic              MOSI;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic [FW-1:0]     rx_data;
    logic              rx_valid;
    logic              MISO;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_valid,
        input  tx_data,
        output rx_data,
        output rx_valid,
        output MISO,
        output frame_err,
        output busy
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_valid,
        output tx_data,
        input  rx_data,
        input  rx_valid,
        input  MISO,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/spi_slave_gen.sv
// SPI slave with command framing. A frame opens with one path-select bit
// (not stored), followed by FW = DATA_W+2 bits: a 2-bit command and the
// payload, MSB first. Read-data frames then wait for tx_valid and shift
// tx_data out on MISO. Dropping SS_n mid-frame aborts with a frame_err pulse.
module spi_slave_gen #(
    parameter int DATA_W      = 8,
    parameter int TX_WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_gen_if.slave bus
);
    localparam int FW     = DATA_W + 2;
    localparam int CNT_W  = $clog2(FW + 1);
    localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_FW    = CNT_W'(FW);
    localparam logic [CNT_W-1:0]  CNT_DW    = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        RX_SHIFT,
        READ_WAIT,
        TX_SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [FW-1:0]     rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic              rx_valid_r;
    logic              frame_err_r;
    logic              miso_r;
    logic              rd_addr_loaded;
    // Expected command captured at the select bit: exp_sel chooses the
    // write path (either write command) or the read path, where exp_ld
    // picks between rd-addr and rd-data.
    logic              exp_sel;
    logic              exp_ld;

    logic [FW-1:0]     rx_next;
    logic [1:0]        rx_cmd;
    logic              cmd_ok;
    logic              abort;

    // Frame as it will look once the current MOSI bit is shifted in; on the
    // last bit this is the complete frame, so the command check uses it.
    assign rx_next = {rx_shift[FW-2:0], bus.MOSI};
    assign rx_cmd  = rx_next[FW-1:FW-2];
    assign cmd_ok  = exp_sel ? (rx_cmd == {1'b1, exp_ld}) : ~rx_cmd[1];

    // SS_n released while a frame is still in progress; this wins over
    // everything else, including the last RX bit and the end of TX.
    assign abort = bus.SS_n &&
                   (state inside {CHK_CMD, RX_SHIFT, READ_WAIT, TX_SHIFT});

    assign bus.rx_data   = rx_shift;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.MISO      = miso_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = (state != IDLE);

    // Frame sequencer: state, counters, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            rx_valid_r     <= 1'b0;
            frame_err_r    <= 1'b0;
            miso_r         <= 1'b0;
            rd_addr_loaded <= 1'b0;
            exp_sel        <= 1'b0;
            exp_ld         <= 1'b0;
        end else begin
            // Pulses and MISO default low; states below raise them.
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            miso_r      <= 1'b0;

            if (abort) begin
                // Partial rx_data and rd_addr_loaded are left untouched.
                state       <= IDLE;
                frame_err_r <= 1'b1;
                bit_cnt     <= '0;
                wait_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.SS_n) begin
                            state <= CHK_CMD;
                        end
                    end

                    CHK_CMD: begin
                        exp_sel  <= bus.MOSI;
                        exp_ld   <= rd_addr_loaded;
                        bit_cnt  <= CNT_FW;
                        rx_shift <= '0;
                        state    <= RX_SHIFT;
                    end

                    RX_SHIFT: begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt - CNT_ONE;
                        if (bit_cnt == CNT_ONE) begin
                            if (cmd_ok) begin
                                rx_valid_r <= 1'b1;
                                if (rx_cmd == CMD_RD_ADDR) begin
                                    rd_addr_loaded <= 1'b1;
                                end
                                if (rx_cmd == CMD_RD_DATA) begin
                                    wait_cnt <= '0;
                                    state    <= READ_WAIT;
                                end else begin
                                    state <= DONE;
                                end
                            end else begin
                                frame_err_r <= 1'b1;
                                state       <= DONE;
                            end
                        end
                    end

                    READ_WAIT: begin
                        if (bus.tx_valid) begin
                            tx_shift <= bus.tx_data;
                            bit_cnt  <= CNT_DW;
                            wait_cnt <= '0;
                            state    <= TX_SHIFT;
                        end else if (wait_cnt == WAIT_LAST) begin
                            frame_err_r <= 1'b1;
                            wait_cnt    <= '0;
                            state       <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_ONE;
                        end
                    end

                    TX_SHIFT: begin
                        if (bit_cnt != '0) begin
                            miso_r   <= tx_shift[DATA_W-1];
                            tx_shift <= tx_shift << 1;
                            bit_cnt  <= bit_cnt - CNT_ONE;
                        end else begin
                            // Read transaction complete: the next read must
                            // start again with an address frame.
                            rd_addr_loaded <= 1'b0;
                            state          <= DONE;
                        end
                    end

                    DONE: begin
                        if (bus.SS_n) begin
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
